sum_accum: RTL and testbench
============================

SUM_ACCUM -- requirements
Module: sum_accum

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand and result width in bits.
REQ-002 Parameter MAX_TERMS, default 16, SHALL set the maximum number of operands per operation.
REQ-003 Derived constant CNT_W = clog2(MAX_TERMS+1) SHALL size the term count and counter.
REQ-004 The design SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  SHALL be the single clock; all logic is rising-edge.
REQ-006 rst  in  1  SHALL be the synchronous, active-high reset.
REQ-007 start  in  1  SHALL request a new operation (sampled in IDLE only).
REQ-008 num_terms  in  CNT_W  SHALL give the operand count for the requested operation.
REQ-009 sat_mode  in  1  SHALL select the overflow mode: 0 = wrap, 1 = saturate.
REQ-010 in_valid  in  1  SHALL mark that the operand is valid.
REQ-011 in_data  in  WIDTH  SHALL carry the unsigned operand.
REQ-012 in_ready  out  1  SHALL indicate that an operand can be accepted.
REQ-013 out_valid  out  1  SHALL indicate that the result is valid.
REQ-014 out_ready  in  1  SHALL indicate that the consumer accepts the result.
REQ-015 out_sum  out  WIDTH  SHALL carry the final sum.
REQ-016 out_ovf  out  1  SHALL carry the sticky overflow flag for the operation.
REQ-017 busy  out  1  SHALL be high whenever the state is not IDLE.

Function
REQ-018 The FSM SHALL have three states: IDLE, ACCUM and DONE.
REQ-019 In IDLE, start=1 SHALL:
- latch sat_mode and min(num_terms, MAX_TERMS);
- clear the accumulator, counter and ovf;
- go to ACCUM next cycle, or to DONE if the latched count is 0.
REQ-020 start SHALL be ignored in ACCUM and DONE; num_terms and sat_mode SHALL be ignored outside the start cycle.
REQ-021 in_ready SHALL be 1 only in ACCUM; an operand is accepted on in_valid && in_ready.
REQ-022 On each accepted operand, the accumulator SHALL add in_data unsigned with one carry bit, and the counter SHALL increment.
REQ-023 Wrap mode on carry: the accumulator SHALL keep the low WIDTH bits and set ovf.
REQ-024 Saturate mode on carry: the accumulator SHALL become all-ones and set ovf; once saturated it stays all-ones.
REQ-025 ovf SHALL be sticky until the next start.
REQ-026 Cycles with in_valid=0 in ACCUM SHALL leave all state unchanged.
REQ-027 On acceptance of the final operand (counter+1 == latched count), the state SHALL go to DONE, and out_valid SHALL rise the next cycle (latency 1).
REQ-028 In DONE, out_valid=1 and out_sum/out_ovf SHALL hold stable until out_ready=1.
REQ-029 out_valid && out_ready SHALL return the state to IDLE next cycle with out_valid=0; a new start is accepted from that IDLE cycle.
REQ-030 out_sum and out_ovf SHALL be 0 whenever out_valid=0.

Reset
REQ-031 rst=1 SHALL force IDLE and clear the accumulator, counter, ovf and latched configuration; all outputs SHALL be 0 on the next edge.
REQ-032 rst SHALL override start and handshakes in the same cycle; a partial operation interrupted by reset SHALL be discarded without producing out_valid.

Structure
REQ-033 Package sum_accum_pkg SHALL hold the state enum typedef and the MODE_WRAP/MODE_SAT constants.
REQ-034 Sub-module sum_sat_add SHALL be the combinational WIDTH-bit adder: inputs a, b, sat; outputs sum, carry.
REQ-035 The top level SHALL contain only the FSM, the counter and the registers.

Verification
REQ-036 WIDTH=8, wrap mode, num_terms=3, data 10, 15, 20 back-to-back -> out_valid one cycle after the third beat, out_sum=45, out_ovf=0.
REQ-037 Wrap mode, num_terms=2, data 200, 100 -> out_sum=44, out_ovf=1; saturate mode, data 200, 100, 5 -> out_sum=255, out_ovf=1.
REQ-038 in_valid gaps of 2 cycles between beats, then out_ready held low 5 cycles -> sum unchanged by gaps, out_sum stable, in_ready=0, start ignored, busy=1.
REQ-039 num_terms=0 -> DONE next cycle with out_sum=0, out_ovf=0; num_terms=20 with MAX_TERMS=16 -> exactly 16 operands accepted.
REQ-040 rst asserted in ACCUM after 2 beats -> next cycle IDLE with all outputs 0; a following start with 1, 2 -> out_sum=3.

Source files
------------

// File: rtl/sum_accum_pkg.sv
// Shared types and constants for the sum_accum block.
// Holds the FSM state encoding and the overflow mode selectors.
package sum_accum_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DONE  = 2'd2
   } state_e;

   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/sum_sat_add.sv
// Combinational unsigned adder with carry-out.
// In saturate mode a carry clamps the sum to all-ones.
module sum_sat_add #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sat,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);

   logic [WIDTH:0] full;

   // widen by one bit so the carry falls out of the add
   always_comb begin
      full  = {1'b0, a} + {1'b0, b};
      carry = full[WIDTH];
      if (carry && sat) begin
         sum = '1;
      end else begin
         sum = full[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/sum_accum.sv
// Accumulates a counted burst of unsigned operands into one sum.
// Result is held with a sticky overflow flag until the consumer takes it.
module sum_accum
   import sum_accum_pkg::*;
#(
   parameter  int WIDTH     = 8,
   parameter  int MAX_TERMS = 16,
   localparam int CNT_W     = $clog2(MAX_TERMS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] num_terms,
   input  logic             sat_mode,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_ovf,
   output logic             busy
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] tgt_q, tgt_d;
   logic             sat_q, sat_d;
   logic             ovf_q, ovf_d;

   logic [CNT_W-1:0] clamp;
   logic [CNT_W-1:0] cnt_inc;
   logic [WIDTH-1:0] add_sum;
   logic             add_carry;

   sum_sat_add #(
      .WIDTH(WIDTH)
   ) u_add (
      .a    (acc_q),
      .b    (in_data),
      .sat  (sat_q == MODE_SAT),
      .sum  (add_sum),
      .carry(add_carry)
   );

   // oversized requests are trimmed to the largest supported burst
   always_comb begin
      clamp   = (num_terms > MAX_CNT) ? MAX_CNT : num_terms;
      cnt_inc = cnt_q + CNT_W'(1);
   end

   // state and datapath registers; reset discards any partial operation
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         tgt_q   <= '0;
         sat_q   <= MODE_WRAP;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         tgt_q   <= tgt_d;
         sat_q   <= sat_d;
         ovf_q   <= ovf_d;
      end
   end

   // next-state and datapath update; every register holds by default
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      tgt_d   = tgt_q;
      sat_d   = sat_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               tgt_d   = clamp;
               sat_d   = sat_mode ? MODE_SAT : MODE_WRAP;
               acc_d   = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
               state_d = (clamp == '0) ? S_DONE : S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (in_valid) begin
               acc_d = add_sum;
               ovf_d = ovf_q | add_carry;
               cnt_d = cnt_inc;
               if (cnt_inc == tgt_q) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // outputs decode from the registered state; result is masked when idle
   always_comb begin
      in_ready  = (state_q == S_ACCUM);
      out_valid = (state_q == S_DONE);
      busy      = (state_q != S_IDLE);
      out_sum   = out_valid ? acc_q : '0;
      out_ovf   = out_valid & ovf_q;
   end

endmodule

// File: tb/tb_sum_accum.sv
// Directed bench for sum_accum with hand-computed expectations.
// Drives one step after each rising edge and checks there too.
module tb_sum_accum;
   import sum_accum_pkg::*;

   logic       clk;
   logic       rst;
   logic       start;
   logic [4:0] num_terms;
   logic       sat_mode;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_sum;
   logic       out_ovf;
   logic       busy;

   int checks   = 0;
   int failures = 0;
   int accepted = 0;

   sum_accum #(
      .WIDTH    (8),
      .MAX_TERMS(16)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .num_terms(num_terms),
      .sat_mode (sat_mode),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_sum  (out_sum),
      .out_ovf  (out_ovf),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic do_start(input logic [4:0] n, input logic m);
      start     = 1'b1;
      num_terms = n;
      sat_mode  = m;
      tick();
      start     = 1'b0;
      num_terms = 5'd31;
      sat_mode  = ~m;
   endtask

   task automatic beat(input logic [7:0] d);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
      in_data  = 8'hAA;
   endtask

   task automatic take();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_busy"},  32'(busy), 32'd0);
      chk({tag, "_sum"},   32'(out_sum), 32'd0);
      chk({tag, "_ovf"},   32'(out_ovf), 32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      num_terms = '0;
      sat_mode  = MODE_WRAP;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      tick();
      tick();
      chk_idle("reset");
      rst = 1'b0;
      tick();

      // three back-to-back beats in wrap mode
      do_start(5'd3, MODE_WRAP);
      chk("b2b_ready", 32'(in_ready), 32'd1);
      chk("b2b_busy", 32'(busy), 32'd1);
      beat(8'd10);
      beat(8'd15);
      chk("b2b_early", 32'(out_valid), 32'd0);
      beat(8'd20);
      chk("b2b_valid", 32'(out_valid), 32'd1);
      chk("b2b_sum", 32'(out_sum), 32'd45);
      chk("b2b_ovf", 32'(out_ovf), 32'd0);
      chk("b2b_noready", 32'(in_ready), 32'd0);
      take();
      chk_idle("b2b_done");

      // wrap overflow: 200 + 100 = 300 -> 44
      do_start(5'd2, MODE_WRAP);
      beat(8'd200);
      beat(8'd100);
      chk("wrap_sum", 32'(out_sum), 32'd44);
      chk("wrap_ovf", 32'(out_ovf), 32'd1);
      take();

      // saturate: clamps at 255 and stays there
      do_start(5'd3, MODE_SAT);
      beat(8'd200);
      beat(8'd100);
      beat(8'd5);
      chk("sat_sum", 32'(out_sum), 32'd255);
      chk("sat_ovf", 32'(out_ovf), 32'd1);
      take();

      // gaps between beats, then a stalled consumer
      do_start(5'd3, MODE_WRAP);
      beat(8'd1);
      tick();
      tick();
      chk("gap_ready", 32'(in_ready), 32'd1);
      chk("gap_valid", 32'(out_valid), 32'd0);
      beat(8'd2);
      tick();
      tick();
      beat(8'd3);
      start     = 1'b1;
      num_terms = 5'd1;
      in_valid  = 1'b1;
      in_data   = 8'd99;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_valid", 32'(out_valid), 32'd1);
         chk("stall_sum", 32'(out_sum), 32'd6);
         chk("stall_ovf", 32'(out_ovf), 32'd0);
         chk("stall_ready", 32'(in_ready), 32'd0);
         chk("stall_busy", 32'(busy), 32'd1);
      end
      start    = 1'b0;
      in_valid = 1'b0;
      take();
      chk_idle("stall_done");

      // zero terms goes straight to DONE
      do_start(5'd0, MODE_WRAP);
      chk("zero_valid", 32'(out_valid), 32'd1);
      chk("zero_sum", 32'(out_sum), 32'd0);
      chk("zero_ovf", 32'(out_ovf), 32'd0);
      take();

      // 20 requested, only 16 accepted
      do_start(5'd20, MODE_WRAP);
      in_valid = 1'b1;
      in_data  = 8'd1;
      accepted = 0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) break;
         if (in_ready) accepted++;
         tick();
      end
      in_valid = 1'b0;
      chk("clamp_count", 32'(accepted), 32'd16);
      chk("clamp_valid", 32'(out_valid), 32'd1);
      chk("clamp_sum", 32'(out_sum), 32'd16);
      take();

      // reset mid-operation discards the partial sum
      do_start(5'd4, MODE_SAT);
      beat(8'd200);
      beat(8'd200);
      rst       = 1'b1;
      start     = 1'b1;
      out_ready = 1'b1;
      tick();
      rst       = 1'b0;
      start     = 1'b0;
      out_ready = 1'b0;
      chk_idle("rst_mid");
      tick();
      tick();
      chk_idle("rst_hold");
      do_start(5'd2, MODE_WRAP);
      beat(8'd1);
      beat(8'd2);
      chk("post_rst_valid", 32'(out_valid), 32'd1);
      chk("post_rst_sum", 32'(out_sum), 32'd3);
      chk("post_rst_ovf", 32'(out_ovf), 32'd0);
      take();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
